mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator-side memory access unit for the M stage of the pipelined CPU. It accepts one load/store per instruction from the pipeline and drives the word-addressed data memory over a request/acknowledge handshake. It holds the pipeline via `stall` until the access completes. Sub-word stores are done as read-modify-write, since the data memory only writes whole words. Sub-word loads are lane-extracted and sign- or zero-extended.

## Interface
Parameters:
- `ADDR_W`, default 12: number of byte-address bits forwarded to the data memory; upper bits of `dm_addr` are driven 0.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: M-stage memory instruction present.
- `req_op`, in, 3: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7.
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data; SB uses [7:0], SH uses [15:0].
- `req_pc`, in, 32: PC of the instruction, used for trace only.
- `stall`, out, 1: hold the pipeline.
- `done`, out, 1: one-cycle completion pulse.
- `rdata`, out, 32: extended load result; valid while `done`=1.
- `misalign`, out, 1: alignment fault; valid while `done`=1.
- `dm_req`, out, 1: memory request.
- `dm_we`, out, 1: request is a write.
- `dm_addr`, out, 32: word-aligned address, bits [1:0] always 0.
- `dm_wdata`, out, 32: full write word.
- `dm_ack`, in, 1: memory accepted or completed the request this cycle.
- `dm_rdata`, in, 32: read word; valid in the cycle `dm_ack`=1 on a read.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - When `req_valid`=1, capture op, address, wdata and pc into registers.
  - Misaligned request → DONE with misalign set. Misaligned means: LW/SW with addr[1:0]≠0, or LH/LHU/SH with addr[0]≠0.
  - Loads, SH and SB → READ.
  - SW → WRITE.
- READ:
  - Drive `dm_req`=1, `dm_we`=0.
  - On `dm_ack`, capture `dm_rdata`.
  - Loads then go to DONE; SH/SB go to WRITE.
- WRITE:
  - Drive `dm_req`=1, `dm_we`=1.
  - `dm_wdata` is `req_wdata` for SW, otherwise the merged word.
  - On `dm_ack` → DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Byte lanes: lane k = addr[1:0] occupies bits [8k+7:8k].
- Halfword: addr[1] selects [15:0] or [31:16].
- Loads:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- SB merge: replace the selected byte with `req_wdata[7:0]`; other bytes keep the read value.
- SH merge: same rule, with `req_wdata[15:0]` and the selected halfword.
- A misaligned request never asserts `dm_req`, and its `rdata` = 0.
- `stall` = `req_valid` && state≠DONE. The pipeline must hold the `req_*` inputs stable while `stall`=1.

## Timing
- Reset values:
  - state IDLE.
  - `stall`, `done`, `misalign`, `dm_req`, `dm_we` all 0.
  - `rdata`, `dm_addr`, `dm_wdata` all 0.
- Reset asserted mid-access drops `dm_req` immediately (asynchronous) and discards the access.
- `dm_req`, `dm_we`, `dm_addr` and `dm_wdata` are held stable from assertion until the cycle of `dm_ack`. `dm_req` deasserts the cycle after `dm_ack`.
- `dm_ack` is ignored while `dm_req`=0.
- Latency, with `dm_ack` on the first cycle of each access and cycle 0 = request seen in IDLE:

| Request | `done` cycle | `stall` high |
|---|---|---|
| Load, SW | 2 | cycles 0–1 |
| SB/SH | 3 | cycles 0–2 |
| Misaligned | 1 | cycle 0 |

- Each cycle `dm_ack` is withheld adds one cycle to the latency.
- The pipeline advances on the DONE edge. A new request is first sampled on the following cycle in IDLE.

## Configuration
- `MEM_TRACE_EN` defined:
  - On each cycle where `dm_we`=1 and `dm_ack`=1, execute `$display("%d@%h: *%h <= %h", $time, pc, dm_addr, dm_wdata)`.
  - `pc` is the captured `req_pc`.
- `MEM_TRACE_EN` undefined: no display.
- Cycle behaviour is identical in both cases.

## Structure
- Shared package `mem_pkg`:
  - op encoding constants `OP_LW` … `OP_SB`.
  - FSM state enum.
  - lane width constants.
- Sub-module `load_store_align`, purely combinational:
  - Inputs: op, addr[1:0], read word, store data.
  - Outputs: extended load value, merged store word, misalign flag.
- The FSM, registers and handshake stay in `mem_access_unit`.

## Test plan
- LW `0x10`, `dm_ack` immediate, `dm_rdata`=`0x8899AABB`:
  - `dm_addr`=`0x10`, `dm_we`=0.
  - `done` at cycle 2, `rdata`=`0x8899AABB`.
  - `stall` high in cycles 0–1.
- LB `0x13`, `dm_rdata`=`0x80112233` → `rdata`=`0xFFFFFF80`.
- LBU, same address and data → `rdata`=`0x00000080`.
- LH `0x2`, `dm_rdata`=`0x7FFF0000` → `rdata`=`0x00007FFF`.
- SB `0x11`, wdata `0x000000CC`, old word `0x11223344`:
  - Read of `0x10`, then write of `0x1122CC44` to `0x10`.
  - `done` at cycle 3.
- SH `0x2`, wdata `0x0000BEEF`, old word `0x11223344` → writes `0xBEEF3344`.
- SW `0x8`, wdata `0xDEADBEEF`:
  - Single write, no read.
  - `dm_ack` delayed 3 cycles → `done` at cycle 5.
  - With `MEM_TRACE_EN`, exactly one trace line prints.
- LW `0x6` → `misalign`=1 and `done` at cycle 1, `dm_req` never asserted, `rdata`=0.
- Reset pulled low during READ with `dm_ack` held 0:
  - `dm_req` and `stall` go 0 immediately.
  - After release, the state is IDLE and the next LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the M-stage memory access unit.
//   - load/store op encodings (OP_LW .. OP_SB)
//   - access FSM state enum
//   - byte/halfword/word lane widths
//   - helper to classify sub-word stores (read-modify-write)
package mem_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } mau_state_e;

  // Sub-word stores need the old word first.
  function automatic logic is_rmw_store(input logic [2:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational lane handling for loads and stores.
// Ports:
//   i_op       load/store op (mem_pkg encoding)
//   i_addr_lo  byte address bits [1:0]
//   i_rd_word  word read from data memory
//   i_st_data  store data from the pipeline
//   o_ld_val   lane-extracted, sign/zero-extended load value
//   o_st_word  full word to write (merged for SB/SH, raw for SW)
//   o_misalign alignment fault for this op/address
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [1:0]        i_addr_lo,
  input  logic [WORD_W-1:0] i_rd_word,
  input  logic [WORD_W-1:0] i_st_data,
  output logic [WORD_W-1:0] o_ld_val,
  output logic [WORD_W-1:0] o_st_word,
  output logic              o_misalign
);

  logic [BYTE_W-1:0] w_byte;
  logic [HALF_W-1:0] w_half;
  logic [4:0]        w_bit_ofs;

  assign w_bit_ofs = {i_addr_lo, 3'b000};
  assign w_byte    = i_rd_word[w_bit_ofs +: BYTE_W];
  assign w_half    = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];

  always_comb begin
    o_ld_val = '0;
    unique case (i_op)
      OP_LW:   o_ld_val = i_rd_word;
      OP_LH:   o_ld_val = {{(WORD_W-HALF_W){w_half[HALF_W-1]}}, w_half};
      OP_LHU:  o_ld_val = {{(WORD_W-HALF_W){1'b0}}, w_half};
      OP_LB:   o_ld_val = {{(WORD_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
      OP_LBU:  o_ld_val = {{(WORD_W-BYTE_W){1'b0}}, w_byte};
      default: o_ld_val = '0;
    endcase
  end

  // Untouched lanes keep the value read back from memory.
  always_comb begin
    o_st_word = i_rd_word;
    unique case (i_op)
      OP_SW: o_st_word = i_st_data;
      OP_SB: o_st_word[w_bit_ofs +: BYTE_W] = i_st_data[BYTE_W-1:0];
      OP_SH: begin
        if (i_addr_lo[1]) o_st_word[31:16] = i_st_data[HALF_W-1:0];
        else              o_st_word[15:0]  = i_st_data[HALF_W-1:0];
      end
      default: o_st_word = i_rd_word;
    endcase
  end

  always_comb begin
    o_misalign = 1'b0;
    unique case (i_op)
      OP_LW, OP_SW:         o_misalign = (i_addr_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH: o_misalign = i_addr_lo[0];
      default:              o_misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store initiator towards word-addressed data
// memory over a req/ack handshake. Sub-word stores are read-modify-write.
// Optional feature macro: MEM_TRACE_EN (prints one line per acknowledged write).
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_op/req_addr/req_wdata/req_pc  pipeline request (held while stall)
//   stall, done, rdata, misalign                 pipeline response
//   dm_req/dm_we/dm_addr/dm_wdata                memory request (held until dm_ack)
//   dm_ack/dm_rdata                              memory response
//
// state   | meaning
// S_IDLE  | waiting for req_valid; captures the request
// S_READ  | memory read (loads, and first half of SB/SH)
// S_WRITE | memory write (SW, and merged word of SB/SH)
// S_DONE  | one-cycle completion, pipeline advances
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  mau_state_e        r_state;
  mau_state_e        w_state_nxt;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rword;
  logic              r_misalign;

  logic [2:0]  w_op;
  logic [1:0]  w_addr_lo;
  logic [31:0] w_ld_val;
  logic [31:0] w_st_word;
  logic        w_misalign;
  logic [31:0] w_dm_addr;
  logic        w_unused_in;

  // In IDLE the align block judges the live request so misalignment can steer
  // the first transition; afterwards it works on the captured copy.
  assign w_op      = (r_state == S_IDLE) ? req_op        : r_op;
  assign w_addr_lo = (r_state == S_IDLE) ? req_addr[1:0] : r_addr[1:0];

  load_store_align u_align (
    .i_op       (w_op),
    .i_addr_lo  (w_addr_lo),
    .i_rd_word  (r_rword),
    .i_st_data  (r_wdata),
    .o_ld_val   (w_ld_val),
    .o_st_word  (w_st_word),
    .o_misalign (w_misalign)
  );

  assign w_dm_addr   = 32'({r_addr[ADDR_W-1:2], 2'b00});
  assign w_unused_in = ^{req_pc, req_addr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misalign)           w_state_nxt = S_DONE;
          else if (req_op == OP_SW) w_state_nxt = S_WRITE;
          else                      w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (dm_ack) w_state_nxt = is_rmw_store(r_op) ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        if (dm_ack) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset is folded into stall so the pipeline is released the moment reset
  // asserts, even though req_valid may still be high.
  always_comb begin
    stall    = reset & req_valid & (r_state != S_DONE);
    done     = 1'b0;
    misalign = 1'b0;
    rdata    = '0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = w_dm_addr;
    dm_wdata = '0;
    unique case (r_state)
      S_READ: dm_req = 1'b1;
      S_WRITE: begin
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_wdata = (r_op == OP_SW) ? r_wdata : w_st_word;
      end
      S_DONE: begin
        done     = 1'b1;
        misalign = r_misalign;
        rdata    = r_misalign ? '0 : w_ld_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= OP_LW;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rword    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_op       <= req_op;
        r_addr     <= req_addr[ADDR_W-1:0];
        r_wdata    <= req_wdata;
        r_misalign <= w_misalign;
      end
      if (r_state == S_READ && dm_ack) r_rword <= dm_rdata;
    end
  end

`ifdef MEM_TRACE_EN
  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_pc <= '0;
    else if (r_state == S_IDLE && req_valid) r_pc <= req_pc;
  end

  always @(posedge clk) begin
    if (reset && dm_we && dm_ack)
      $display("%d@%h: *%h <= %h", $time, r_pc, dm_addr, dm_wdata);
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        stall, done, misalign, dm_req, dm_we;
  logic [31:0] rdata, dm_addr, dm_wdata;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'hDEAD0000;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  logic [31:0] mem [0:63];
  int          ack_delay = 0;
  int          wcnt = 0;
  int          rd_cnt = 0, wr_cnt = 0, req_seen = 0;
  logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  int          n_tests = 0, n_fail = 0;

  // Memory responder: ack after ack_delay waiting cycles; read data only valid with ack.
  always @(negedge clk) begin
    if (dm_req) begin
      req_seen++;
      if (wcnt >= ack_delay) begin
        dm_ack   = 1'b1;
        dm_rdata = mem[dm_addr[7:2]];
        wcnt     = 0;
      end else begin
        dm_ack   = 1'b0;
        dm_rdata = 32'hDEAD0000;
        wcnt++;
      end
    end else begin
      dm_ack   = 1'b0;
      dm_rdata = 32'hDEAD0000;
      wcnt     = 0;
    end
  end

  always @(posedge clk) begin
    if (dm_req && dm_ack) begin
      if (dm_we) begin
        wr_cnt++;
        last_wr_addr = dm_addr;
        last_wr_data = dm_wdata;
        mem[dm_addr[7:2]] = dm_wdata;
      end else begin
        rd_cnt++;
        last_rd_addr = dm_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issues one request; cycle 0 is the cycle the request is first seen in IDLE.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int dly,
                         output int dcyc, output int scnt,
                         output logic [31:0] rd, output logic mis);
    ack_delay = dly;
    rd_cnt = 0; wr_cnt = 0; req_seen = 0;
    last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    req_pc = 32'h0000_1000 + addr;
    dcyc = -1; scnt = 0; rd = '0; mis = 1'b0;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (stall) scnt++;
      if (done) begin
        dcyc = c; rd = rdata; mis = misalign;
        break;
      end
      @(negedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  int          dc, sc;
  logic [31:0] rd;
  logic        mi;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;

    req_valid = 1'b1;
    #2;
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_misalign", {31'd0, misalign}, 0);
    chk("rst_dm_req", {31'd0, dm_req}, 0);
    chk("rst_dm_we", {31'd0, dm_we}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    mem[4] = 32'h8899AABB;
    run_req(OP_LW, 32'h10, 32'h0, 0, dc, sc, rd, mi);
    chk("lw_done_cyc", dc, 2);
    chk("lw_stall_cyc", sc, 2);
    chk("lw_rdata", rd, 32'h8899AABB);
    chk("lw_misalign", {31'd0, mi}, 0);
    chk("lw_rd_addr", last_rd_addr, 32'h10);
    chk("lw_rd_cnt", rd_cnt, 1);
    chk("lw_wr_cnt", wr_cnt, 0);

    mem[4] = 32'h80112233;
    run_req(OP_LB, 32'h13, 32'h0, 0, dc, sc, rd, mi);
    chk("lb_rdata", rd, 32'hFFFFFF80);
    chk("lb_done_cyc", dc, 2);
    run_req(OP_LBU, 32'h13, 32'h0, 0, dc, sc, rd, mi);
    chk("lbu_rdata", rd, 32'h00000080);

    mem[0] = 32'h7FFF0000;
    run_req(OP_LH, 32'h2, 32'h0, 0, dc, sc, rd, mi);
    chk("lh_rdata", rd, 32'h00007FFF);
    chk("lh_rd_addr", last_rd_addr, 32'h0);

    mem[0] = 32'h80010000;
    run_req(OP_LH, 32'h2, 32'h0, 0, dc, sc, rd, mi);
    chk("lh_neg_rdata", rd, 32'hFFFF8001);
    run_req(OP_LHU, 32'h2, 32'h0, 0, dc, sc, rd, mi);
    chk("lhu_rdata", rd, 32'h00008001);

    mem[4] = 32'h11223344;
    run_req(OP_SB, 32'h11, 32'h000000CC, 0, dc, sc, rd, mi);
    chk("sb_done_cyc", dc, 3);
    chk("sb_stall_cyc", sc, 3);
    chk("sb_rd_addr", last_rd_addr, 32'h10);
    chk("sb_wr_addr", last_wr_addr, 32'h10);
    chk("sb_wr_data", last_wr_data, 32'h1122CC44);
    chk("sb_rd_cnt", rd_cnt, 1);
    chk("sb_wr_cnt", wr_cnt, 1);

    mem[4] = 32'h11223344;
    run_req(OP_SB, 32'h13, 32'hFFFFFFAB, 0, dc, sc, rd, mi);
    chk("sb3_wr_data", last_wr_data, 32'hAB223344);

    mem[0] = 32'h11223344;
    run_req(OP_SH, 32'h2, 32'h0000BEEF, 0, dc, sc, rd, mi);
    chk("sh_wr_data", last_wr_data, 32'hBEEF3344);
    chk("sh_done_cyc", dc, 3);

    mem[0] = 32'h11223344;
    run_req(OP_SH, 32'h0, 32'hFFFF1357, 0, dc, sc, rd, mi);
    chk("sh_lo_wr_data", last_wr_data, 32'h11221357);

    mem[2] = 32'h0;
    run_req(OP_SW, 32'h8, 32'hDEADBEEF, 3, dc, sc, rd, mi);
    chk("sw_done_cyc", dc, 5);
    chk("sw_stall_cyc", sc, 5);
    chk("sw_rd_cnt", rd_cnt, 0);
    chk("sw_wr_cnt", wr_cnt, 1);
    chk("sw_wr_addr", last_wr_addr, 32'h8);
    chk("sw_wr_data", last_wr_data, 32'hDEADBEEF);

    mem[4] = 32'h0F0F0F0F;
    run_req(OP_LW, 32'h10, 32'h0, 2, dc, sc, rd, mi);
    chk("lw_dly_done_cyc", dc, 4);
    chk("lw_dly_rdata", rd, 32'h0F0F0F0F);

    run_req(OP_LW, 32'h6, 32'h0, 0, dc, sc, rd, mi);
    chk("mis_lw_done_cyc", dc, 1);
    chk("mis_lw_flag", {31'd0, mi}, 1);
    chk("mis_lw_rdata", rd, 0);
    chk("mis_lw_req_seen", req_seen, 0);

    run_req(OP_SH, 32'h3, 32'h1234, 0, dc, sc, rd, mi);
    chk("mis_sh_done_cyc", dc, 1);
    chk("mis_sh_flag", {31'd0, mi}, 1);
    chk("mis_sh_req_seen", req_seen, 0);

    run_req(OP_LB, 32'h7, 32'h0, 0, dc, sc, rd, mi);
    chk("lb_odd_misalign", {31'd0, mi}, 0);

    // Reset asserted while a read is outstanding.
    ack_delay = 100;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h20; req_wdata = '0;
    @(negedge clk); #1;
    chk("rst_mid_pre_req", {31'd0, dm_req}, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_dm_req", {31'd0, dm_req}, 0);
    chk("rst_mid_stall", {31'd0, stall}, 0);
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_after_dm_req", {31'd0, dm_req}, 0);
    chk("rst_after_done", {31'd0, done}, 0);
    mem[8] = 32'h0BADF00D;
    run_req(OP_LW, 32'h20, 32'h0, 0, dc, sc, rd, mi);
    chk("rst_after_lw_done_cyc", dc, 2);
    chk("rst_after_lw_rdata", rd, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
